vx_barrier_unit: RTL and testbench

- Consumer side of the warp-control barrier channel.
- Accepts barrier arrivals committed by the warp-control unit and tracks per-barrier arrival counts and waiting-warp masks.
- Drives the per-warp barrier stall mask that the scheduler uses to gate issue.
- For global barriers, performs a request/response handshake with the cluster-level global barrier once all local warps have arrived.

---
 rtl/vx_barrier_unit_pkg.sv | 38 +++
 rtl/vx_barrier_unit_if.sv | 40 ++++
 rtl/vx_barrier_unit_slot.sv | 101 ++++++++++
 rtl/vx_barrier_unit.sv | 133 +++++++++++++
 tb/tb_vx_barrier_unit.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vx_barrier_unit_pkg.sv
// Shared types and widths for the barrier unit: slot/arbiter states, the
// global-barrier request payload and the size-field helper.
package vx_barrier_unit_pkg;

    localparam int unsigned VX_NUM_WARPS    = 4;
    localparam int unsigned VX_NUM_BARRIERS = 4;
    localparam int unsigned VX_NUM_CORES    = 4;

    localparam int unsigned NW_WIDTH = (VX_NUM_WARPS > 1)    ? $clog2(VX_NUM_WARPS)    : 1;
    localparam int unsigned NB_BITS  = (VX_NUM_BARRIERS > 1) ? $clog2(VX_NUM_BARRIERS) : 1;
    localparam int unsigned NC_WIDTH = (VX_NUM_CORES > 1)    ? $clog2(VX_NUM_CORES)    : 1;

    // Core count sits in the upper field of the warp-sized size operand.
    localparam int unsigned GS_LSB = (NW_WIDTH > NC_WIDTH) ? (NW_WIDTH - NC_WIDTH) : 0;

    typedef enum logic [1:0] {
        SLOT_IDLE    = 2'd0,
        SLOT_COLLECT = 2'd1,
        SLOT_GPEND   = 2'd2,
        SLOT_GWAIT   = 2'd3
    } slot_state_e;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [NB_BITS-1:0]  id;
        logic [NC_WIDTH-1:0] size_m1;
        logic [NC_WIDTH-1:0] core_id;
    } gbar_req_t;

    function automatic logic [NC_WIDTH-1:0] gsize_of(input logic [NW_WIDTH-1:0] size_m1);
        return NC_WIDTH'(size_m1 >> GS_LSB);
    endfunction

endpackage

// File: rtl/vx_barrier_unit_if.sv
// Barrier channel: arrivals from warp control, stall mask to the scheduler,
// and the request/response pair towards the cluster global barrier.
interface vx_barrier_unit_if
    import vx_barrier_unit_pkg::*;
#(
    parameter int unsigned NUM_WARPS = VX_NUM_WARPS
);
    logic                 arr_valid;
    logic [NW_WIDTH-1:0]  arr_wid;
    logic [NB_BITS-1:0]   arr_id;
    logic                 arr_is_global;
    logic                 arr_is_noop;
    logic [NW_WIDTH-1:0]  arr_size_m1;

    logic [NUM_WARPS-1:0] barrier_stalls;

    logic                 gbar_req_valid;
    logic [NB_BITS-1:0]   gbar_req_id;
    logic [NC_WIDTH-1:0]  gbar_req_size_m1;
    logic [NC_WIDTH-1:0]  gbar_req_core_id;
    logic                 gbar_req_ready;

    logic                 gbar_rsp_valid;
    logic [NB_BITS-1:0]   gbar_rsp_id;

    modport master (
        output arr_valid, arr_wid, arr_id, arr_is_global, arr_is_noop, arr_size_m1,
        output gbar_req_ready, gbar_rsp_valid, gbar_rsp_id,
        input  barrier_stalls,
        input  gbar_req_valid, gbar_req_id, gbar_req_size_m1, gbar_req_core_id
    );

    modport slave (
        input  arr_valid, arr_wid, arr_id, arr_is_global, arr_is_noop, arr_size_m1,
        input  gbar_req_ready, gbar_rsp_valid, gbar_rsp_id,
        output barrier_stalls,
        output gbar_req_valid, gbar_req_id, gbar_req_size_m1, gbar_req_core_id
    );

endinterface

// File: rtl/vx_barrier_unit_slot.sv
// One barrier slot: arrival count, waiting-warp mask and global handshake
// state, plus the per-cycle stall set/clear contribution of this slot.
module vx_barrier_unit_slot
    import vx_barrier_unit_pkg::*;
#(
    parameter int unsigned NUM_WARPS = VX_NUM_WARPS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arr_hit,
    input  logic [NW_WIDTH-1:0]  arr_wid,
    input  logic                 arr_is_global,
    input  logic [NW_WIDTH-1:0]  arr_size_m1,
    input  logic                 req_accept,
    input  logic                 rsp_hit,
    output slot_state_e          state,
    output logic [NC_WIDTH-1:0]  gsize,
    output logic [NUM_WARPS-1:0] stall_set_c,
    output logic [NUM_WARPS-1:0] stall_clr_c
);

    slot_state_e          state_n;
    logic [NW_WIDTH-1:0]  count, count_n;
    logic [NUM_WARPS-1:0] mask, mask_n;
    logic [NC_WIDTH-1:0]  gsize_n;
    logic [NUM_WARPS-1:0] wid_bit;

    assign wid_bit = NUM_WARPS'(1) << arr_wid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SLOT_IDLE;
            count <= '0;
            mask  <= '0;
            gsize <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            mask  <= mask_n;
            gsize <= gsize_n;
        end
    end

    // Arrivals are only honoured while collecting; GPEND/GWAIT ignore them.
    always_comb begin
        state_n     = state;
        count_n     = count;
        mask_n      = mask;
        gsize_n     = gsize;
        stall_set_c = '0;
        stall_clr_c = '0;
        case (state)
            SLOT_IDLE, SLOT_COLLECT: begin
                if (arr_hit) begin
                    if (count != arr_size_m1) begin
                        mask_n      = mask | wid_bit;
                        count_n     = count + NW_WIDTH'(1);
                        state_n     = SLOT_COLLECT;
                        stall_set_c = wid_bit;
                    end else if (arr_is_global) begin
                        mask_n      = mask | wid_bit;
                        count_n     = '0;
                        gsize_n     = gsize_of(arr_size_m1);
                        state_n     = SLOT_GPEND;
                        stall_set_c = wid_bit;
                    end else begin
                        stall_clr_c = mask;
                        mask_n      = '0;
                        count_n     = '0;
                        state_n     = SLOT_IDLE;
                    end
                end
            end
            SLOT_GPEND: begin
                if (req_accept) begin
                    state_n = SLOT_GWAIT;
                end
            end
            SLOT_GWAIT: begin
                if (rsp_hit) begin
                    stall_clr_c = mask;
                    mask_n      = '0;
                    state_n     = SLOT_IDLE;
                end
            end
            default: begin
                state_n = SLOT_IDLE;
            end
        endcase
    end

    a_arr_collecting: assert property (@(posedge clk) disable iff (reset)
        arr_hit |-> (state == SLOT_IDLE || state == SLOT_COLLECT));

    a_arr_not_dup: assert property (@(posedge clk) disable iff (reset)
        arr_hit |-> !mask[arr_wid]);

    a_rsp_in_gwait: assert property (@(posedge clk) disable iff (reset)
        rsp_hit |-> (state == SLOT_GWAIT));

endmodule

// File: rtl/vx_barrier_unit.sv
// Barrier unit top: per-slot trackers, lowest-index global request arbiter
// and the registered per-warp stall mask.
module vx_barrier_unit
    import vx_barrier_unit_pkg::*;
#(
    parameter int unsigned NUM_WARPS    = VX_NUM_WARPS,
    parameter int unsigned NUM_BARRIERS = VX_NUM_BARRIERS,
    parameter int unsigned CORE_ID      = 0
) (
    input  logic             clk,
    input  logic             reset,
    vx_barrier_unit_if.slave bar_if
);

    slot_state_e          slot_state [NUM_BARRIERS];
    logic [NC_WIDTH-1:0]  slot_gsize [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] slot_set   [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] slot_clr   [NUM_BARRIERS];
    logic [NUM_BARRIERS-1:0] req_accept;

    logic [NUM_WARPS-1:0] stalls;
    logic [NUM_WARPS-1:0] set_all, clr_all;

    arb_state_e arb_state, arb_state_n;
    gbar_req_t  req_q, req_n;
    logic       accept;
    logic       pend_found;
    logic [NB_BITS-1:0] pend_id;

    assign accept = (arb_state == ARB_HOLD) && bar_if.gbar_req_ready;

    for (genvar b = 0; b < NUM_BARRIERS; b++) begin : g_slot
        vx_barrier_unit_slot #(
            .NUM_WARPS (NUM_WARPS)
        ) u_slot (
            .clk           (clk),
            .reset         (reset),
            .arr_hit       (bar_if.arr_valid && !bar_if.arr_is_noop
                            && (bar_if.arr_id == NB_BITS'(b))),
            .arr_wid       (bar_if.arr_wid),
            .arr_is_global (bar_if.arr_is_global),
            .arr_size_m1   (bar_if.arr_size_m1),
            .req_accept    (req_accept[b]),
            .rsp_hit       (bar_if.gbar_rsp_valid && (bar_if.gbar_rsp_id == NB_BITS'(b))),
            .state         (slot_state[b]),
            .gsize         (slot_gsize[b]),
            .stall_set_c   (slot_set[b]),
            .stall_clr_c   (slot_clr[b])
        );
        assign req_accept[b] = accept && (req_q.id == NB_BITS'(b));
    end

    // Lowest-index GPEND slot, skipping the one being accepted this cycle.
    always_comb begin
        pend_found = 1'b0;
        pend_id    = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            if (!pend_found && slot_state[b] == SLOT_GPEND && !req_accept[b]) begin
                pend_found = 1'b1;
                pend_id    = NB_BITS'(b);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            arb_state <= ARB_IDLE;
            req_q     <= '{id: '0, size_m1: '0, core_id: NC_WIDTH'(CORE_ID)};
        end else begin
            arb_state <= arb_state_n;
            req_q     <= req_n;
        end
    end

    // Request payload is latched once and held until accepted.
    always_comb begin
        arb_state_n = arb_state;
        req_n       = req_q;
        case (arb_state)
            ARB_IDLE: begin
                if (pend_found) begin
                    arb_state_n = ARB_HOLD;
                    req_n       = '{id: pend_id, size_m1: slot_gsize[pend_id],
                                    core_id: NC_WIDTH'(CORE_ID)};
                end
            end
            ARB_HOLD: begin
                if (accept) begin
                    if (pend_found) begin
                        req_n = '{id: pend_id, size_m1: slot_gsize[pend_id],
                                  core_id: NC_WIDTH'(CORE_ID)};
                    end else begin
                        arb_state_n = ARB_IDLE;
                    end
                end
            end
            default: begin
                arb_state_n = ARB_IDLE;
            end
        endcase
    end

    always_comb begin
        set_all = '0;
        clr_all = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            set_all = set_all | slot_set[b];
            clr_all = clr_all | slot_clr[b];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stalls <= '0;
        end else begin
            stalls <= (stalls & ~clr_all) | set_all;
        end
    end

    assign bar_if.barrier_stalls   = stalls;
    assign bar_if.gbar_req_valid   = (arb_state == ARB_HOLD);
    assign bar_if.gbar_req_id      = req_q.id;
    assign bar_if.gbar_req_size_m1 = req_q.size_m1;
    assign bar_if.gbar_req_core_id = req_q.core_id;

    a_arr_not_stalled: assert property (@(posedge clk) disable iff (reset)
        (bar_if.arr_valid && !bar_if.arr_is_noop) |-> !stalls[bar_if.arr_wid]);

    a_size_in_range: assert property (@(posedge clk) disable iff (reset)
        (bar_if.arr_valid && !bar_if.arr_is_noop)
            |-> ({1'b0, bar_if.arr_size_m1} < (NW_WIDTH + 1)'(NUM_WARPS)));

endmodule

// File: tb/tb_vx_barrier_unit.sv
// Directed bench for vx_barrier_unit: local, no-op, global, arbitration,
// same-cycle merge and mid-operation reset scenarios.
module tb_vx_barrier_unit;
    import vx_barrier_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    vx_barrier_unit_if bif ();

    vx_barrier_unit #(
        .NUM_WARPS    (4),
        .NUM_BARRIERS (4),
        .CORE_ID      (0)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bar_if (bif)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bif.arr_valid      = 1'b0;
        bif.arr_wid        = '0;
        bif.arr_id         = '0;
        bif.arr_is_global  = 1'b0;
        bif.arr_is_noop    = 1'b0;
        bif.arr_size_m1    = '0;
        bif.gbar_req_ready = 1'b0;
        bif.gbar_rsp_valid = 1'b0;
        bif.gbar_rsp_id    = '0;
    endtask

    task automatic set_arrival(input int wid, input int id, input int sm1,
                               input bit glob, input bit noop);
        bif.arr_valid     = 1'b1;
        bif.arr_wid       = NW_WIDTH'(wid);
        bif.arr_id        = NB_BITS'(id);
        bif.arr_size_m1   = NW_WIDTH'(sm1);
        bif.arr_is_global = glob;
        bif.arr_is_noop   = noop;
    endtask

    task automatic arrive(input int wid, input int id, input int sm1,
                          input bit glob, input bit noop);
        set_arrival(wid, id, sm1, glob, noop);
        tick();
        bif.arr_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        tick();
        tick();
        n_cmp++;
        if (bif.barrier_stalls !== 4'b0000) begin
            n_fail++; $display("FAIL reset_stalls: got %b want 0000", bif.barrier_stalls);
        end
        n_cmp++;
        if (bif.gbar_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_req_valid: got %b want 0", bif.gbar_req_valid);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (bif.gbar_req_core_id !== 2'd0) begin
            n_fail++; $display("FAIL core_id: got %0d want 0", bif.gbar_req_core_id);
        end
    endtask

    task automatic test_local();
        arrive(0, 1, 2, 1'b0, 1'b0);
        n_cmp++;
        if (bif.barrier_stalls !== 4'b0001) begin
            n_fail++; $display("FAIL local_w0: got %b want 0001", bif.barrier_stalls);
        end
        arrive(1, 1, 2, 1'b0, 1'b0);
        n_cmp++;
        if (bif.barrier_stalls !== 4'b0011) begin
            n_fail++; $display("FAIL local_w1: got %b want 0011", bif.barrier_stalls);
        end
        arrive(2, 1, 2, 1'b0, 1'b0);
        n_cmp++;
        if (bif.barrier_stalls !== 4'b0000) begin
            n_fail++; $display("FAIL local_release: got %b want 0000", bif.barrier_stalls);
        end
        // Slot 1 must be back to IDLE with count 0: a fresh 2-warp barrier works.
        arrive(2, 1, 1, 1'b0, 1'b0);
        n_cmp++;
        if (bif.barrier_stalls !== 4'b0100) begin
            n_fail++; $display("FAIL local_restart: got %b want 0100", bif.barrier_stalls);
        end
        arrive(3, 1, 1, 1'b0, 1'b0);
        n_cmp++;
        if (bif.barrier_stalls !== 4'b0000) begin
            n_fail++; $display("FAIL local_restart_rel: got %b want 0000", bif.barrier_stalls);
        end
    endtask

    task automatic test_noop();
        arrive(3, 0, 1, 1'b0, 1'b1);
        n_cmp++;
        if (bif.barrier_stalls !== 4'b0000) begin
            n_fail++; $display("FAIL noop_stalls: got %b want 0000", bif.barrier_stalls);
        end
        tick();
        n_cmp++;
        if (bif.gbar_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL noop_req: got %b want 0", bif.gbar_req_valid);
        end
    endtask

    task automatic test_global();
        for (int w = 0; w < 4; w++) arrive(w, 2, 3, 1'b1, 1'b0);
        n_cmp++;
        if (bif.barrier_stalls !== 4'b1111) begin
            n_fail++; $display("FAIL glob_stalls: got %b want 1111", bif.barrier_stalls);
        end
        n_cmp++;
        if (bif.gbar_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL glob_req_early: got %b want 0", bif.gbar_req_valid);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (bif.gbar_req_valid !== 1'b1 || bif.gbar_req_id !== 2'd2
                || bif.gbar_req_size_m1 !== 2'd3) begin
                n_fail++;
                $display("FAIL glob_hold%0d: valid=%b id=%0d size=%0d want 1/2/3",
                         c, bif.gbar_req_valid, bif.gbar_req_id, bif.gbar_req_size_m1);
            end
        end
        bif.gbar_req_ready = 1'b1;
        tick();
        bif.gbar_req_ready = 1'b0;
        n_cmp++;
        if (bif.gbar_req_valid !== 1'b0 || bif.barrier_stalls !== 4'b1111) begin
            n_fail++; $display("FAIL glob_accept: valid=%b stalls=%b want 0/1111",
                               bif.gbar_req_valid, bif.barrier_stalls);
        end
        bif.gbar_rsp_valid = 1'b1;
        bif.gbar_rsp_id    = 2'd2;
        tick();
        bif.gbar_rsp_valid = 1'b0;
        n_cmp++;
        if (bif.barrier_stalls !== 4'b0000) begin
            n_fail++; $display("FAIL glob_release: got %b want 0000", bif.barrier_stalls);
        end
    endtask

    task automatic test_two_global();
        arrive(0, 0, 1, 1'b1, 1'b0);
        arrive(2, 3, 1, 1'b1, 1'b0);
        arrive(1, 0, 1, 1'b1, 1'b0);
        arrive(3, 3, 1, 1'b1, 1'b0);
        n_cmp++;
        if (bif.barrier_stalls !== 4'b1111) begin
            n_fail++; $display("FAIL two_stalls: got %b want 1111", bif.barrier_stalls);
        end
        n_cmp++;
        if (bif.gbar_req_valid !== 1'b1 || bif.gbar_req_id !== 2'd0
            || bif.gbar_req_size_m1 !== 2'd1) begin
            n_fail++; $display("FAIL two_first: valid=%b id=%0d size=%0d want 1/0/1",
                               bif.gbar_req_valid, bif.gbar_req_id, bif.gbar_req_size_m1);
        end
        bif.gbar_req_ready = 1'b1;
        tick();
        n_cmp++;
        if (bif.gbar_req_valid !== 1'b1 || bif.gbar_req_id !== 2'd3) begin
            n_fail++; $display("FAIL two_second: valid=%b id=%0d want 1/3",
                               bif.gbar_req_valid, bif.gbar_req_id);
        end
        tick();
        bif.gbar_req_ready = 1'b0;
        n_cmp++;
        if (bif.gbar_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL two_drained: got %b want 0", bif.gbar_req_valid);
        end
        bif.gbar_rsp_valid = 1'b1;
        bif.gbar_rsp_id    = 2'd3;
        tick();
        n_cmp++;
        if (bif.barrier_stalls !== 4'b0011) begin
            n_fail++; $display("FAIL two_rel3: got %b want 0011", bif.barrier_stalls);
        end
        bif.gbar_rsp_id = 2'd0;
        tick();
        bif.gbar_rsp_valid = 1'b0;
        n_cmp++;
        if (bif.barrier_stalls !== 4'b0000) begin
            n_fail++; $display("FAIL two_rel0: got %b want 0000", bif.barrier_stalls);
        end
    endtask

    task automatic test_same_cycle();
        arrive(0, 2, 2, 1'b1, 1'b0);
        arrive(2, 2, 2, 1'b1, 1'b0);
        arrive(3, 2, 2, 1'b1, 1'b0);
        n_cmp++;
        if (bif.barrier_stalls !== 4'b1101) begin
            n_fail++; $display("FAIL same_setup: got %b want 1101", bif.barrier_stalls);
        end
        tick();
        n_cmp++;
        if (bif.gbar_req_valid !== 1'b1 || bif.gbar_req_size_m1 !== 2'd2) begin
            n_fail++; $display("FAIL same_req: valid=%b size=%0d want 1/2",
                               bif.gbar_req_valid, bif.gbar_req_size_m1);
        end
        bif.gbar_req_ready = 1'b1;
        tick();
        bif.gbar_req_ready = 1'b0;
        // Response for slot 2 together with a local arrival on slot 0.
        bif.gbar_rsp_valid = 1'b1;
        bif.gbar_rsp_id    = 2'd2;
        set_arrival(1, 0, 1, 1'b0, 1'b0);
        tick();
        bif.arr_valid      = 1'b0;
        bif.gbar_rsp_valid = 1'b0;
        n_cmp++;
        if (bif.barrier_stalls !== 4'b0010) begin
            n_fail++; $display("FAIL same_merge: got %b want 0010", bif.barrier_stalls);
        end
    endtask

    task automatic test_reset_midop();
        arrive(0, 3, 1, 1'b1, 1'b0);
        arrive(3, 3, 1, 1'b1, 1'b0);
        tick();
        n_cmp++;
        if (bif.barrier_stalls !== 4'b1011 || bif.gbar_req_valid !== 1'b1
            || bif.gbar_req_id !== 2'd3) begin
            n_fail++; $display("FAIL rst_setup: stalls=%b valid=%b id=%0d want 1011/1/3",
                               bif.barrier_stalls, bif.gbar_req_valid, bif.gbar_req_id);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (bif.barrier_stalls !== 4'b0000 || bif.gbar_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_clear: stalls=%b valid=%b want 0000/0",
                               bif.barrier_stalls, bif.gbar_req_valid);
        end
        tick();
        n_cmp++;
        if (bif.gbar_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_no_req: got %b want 0", bif.gbar_req_valid);
        end
        arrive(1, 0, 1, 1'b0, 1'b0);
        n_cmp++;
        if (bif.barrier_stalls !== 4'b0010) begin
            n_fail++; $display("FAIL rst_count0: got %b want 0010", bif.barrier_stalls);
        end
        arrive(0, 0, 1, 1'b0, 1'b0);
        n_cmp++;
        if (bif.barrier_stalls !== 4'b0000) begin
            n_fail++; $display("FAIL rst_release: got %b want 0000", bif.barrier_stalls);
        end
    endtask

    initial begin
        test_reset();
        test_local();
        test_noop();
        test_global();
        test_two_global();
        test_same_cycle();
        test_reset_midop();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
